// File: rtl/ysyx_22050039_lut_pkg.sv
// Shared definitions for the LUT reverse-search block: FSM state encoding
// and the derived-width helpers used by the top level and the group matcher.
package ysyx_22050039_lut_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StResp = 2'd2
    } lut_state_e;

    // Width of one key/data pair.
    function automatic int unsigned calc_pair_len(input int unsigned key_len,
                                                  input int unsigned data_len);
        return key_len + data_len;
    endfunction

    // clog2 with a floor of 1 so single-entry indices still get a real bit.
    function automatic int unsigned calc_idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lut_group_match.sv
// Combinational compare of one group of STRIDE key/data pairs against the
// search value. Reports the lowest-index matching pair among the lanes that
// are enabled in valid_mask.
module lut_group_match
    import ysyx_22050039_lut_pkg::*;
#(
    parameter int unsigned STRIDE   = 1,
    parameter int unsigned KEY_LEN  = 1,
    parameter int unsigned DATA_LEN = 1,
    parameter int unsigned IDX_W    = 1
) (
    input  logic [STRIDE*(KEY_LEN+DATA_LEN)-1:0] pairs,
    input  logic [IDX_W-1:0]                     base_index,
    input  logic [STRIDE-1:0]                    valid_mask,
    input  logic [DATA_LEN-1:0]                  search_data,
    output logic                                 hit,
    output logic [KEY_LEN-1:0]                   key,
    output logic [IDX_W-1:0]                     index
);

    localparam int unsigned PAIR_LEN = calc_pair_len(KEY_LEN, DATA_LEN);

    // Priority scan: the first enabled lane that matches wins, later lanes are ignored.
    always_comb begin
        hit   = 1'b0;
        key   = '0;
        index = '0;
        for (int unsigned i = 0; i < STRIDE; i++) begin
            if (!hit && valid_mask[i] &&
                (pairs[i*PAIR_LEN +: DATA_LEN] == search_data)) begin
                hit   = 1'b1;
                key   = pairs[i*PAIR_LEN+DATA_LEN +: KEY_LEN];
                index = base_index + IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/lut_reverse_search.sv
// Sequential data-to-key reverse lookup over a packed key/data LUT.
// Scans STRIDE pairs per cycle, stops at the first (lowest-index) hit and
// hands the result out on a valid/ready response channel.
// Optional: define YSYX_22050039_LUT_SNAPSHOT_EN to capture the whole lut on
// accept so later lut changes cannot affect an in-flight search.
module lut_reverse_search
    import ysyx_22050039_lut_pkg::*;
#(
    parameter  int unsigned NR_KEY   = 2,
    parameter  int unsigned KEY_LEN  = 1,
    parameter  int unsigned DATA_LEN = 1,
    parameter  int unsigned STRIDE   = 1,
    localparam int unsigned IDX_W    = calc_idx_w(NR_KEY)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [DATA_LEN-1:0]                  req_data,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
    output logic                                 resp_valid,
    input  logic                                 resp_ready,
    output logic                                 resp_hit,
    output logic [KEY_LEN-1:0]                   resp_key,
    output logic [IDX_W-1:0]                     resp_index
);

    localparam int unsigned PAIR_LEN = calc_pair_len(KEY_LEN, DATA_LEN);
    localparam int unsigned NR_GRP   = (NR_KEY + STRIDE - 1) / STRIDE;
    localparam int unsigned GRP_W    = calc_idx_w(NR_GRP);
    localparam int unsigned PAD_KEY  = NR_GRP * STRIDE;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NR_GRP - 1);

    lut_state_e                   state_q, state_d;
    logic [GRP_W-1:0]             grp_q;
    logic [DATA_LEN-1:0]          data_q;
    logic                         hit_q;
    logic [KEY_LEN-1:0]           key_q;
    logic [IDX_W-1:0]             idx_q;

    logic [NR_KEY*PAIR_LEN-1:0]   src_lut;
    logic [PAD_KEY*PAIR_LEN-1:0]  lut_pad;
    logic [STRIDE*PAIR_LEN-1:0]   window;
    logic [STRIDE-1:0]            valid_mask;
    logic [IDX_W-1:0]             base_index;
    logic                         m_hit;
    logic [KEY_LEN-1:0]           m_key;
    logic [IDX_W-1:0]             m_idx;
    logic                         accept;
    logic                         last_grp;

    assign accept   = req_valid && (state_q == StIdle);
    assign last_grp = (grp_q == LAST_GRP);

`ifdef YSYX_22050039_LUT_SNAPSHOT_EN
    logic [NR_KEY*PAIR_LEN-1:0] snap_q;

    // Freeze the table at accept so the scan is immune to later lut writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
        end else if (accept && !flush) begin
            snap_q <= lut;
        end
    end

    assign src_lut = snap_q;
`else
    assign src_lut = lut;
`endif

    // Zero-pad to a whole number of groups; the padded lanes are masked off anyway.
    if (PAD_KEY > NR_KEY) begin : g_pad
        assign lut_pad = {{((PAD_KEY - NR_KEY) * PAIR_LEN){1'b0}}, src_lut};
    end else begin : g_nopad
        assign lut_pad = src_lut;
    end

    // Select the current group's pairs, its first index and which lanes are real.
    always_comb begin
        window     = lut_pad[STRIDE*PAIR_LEN-1:0];
        base_index = '0;
        valid_mask = '0;
        for (int unsigned gi = 0; gi < NR_GRP; gi++) begin
            if (grp_q == GRP_W'(gi)) begin
                window     = lut_pad[gi*STRIDE*PAIR_LEN +: STRIDE*PAIR_LEN];
                base_index = IDX_W'(gi * STRIDE);
                for (int unsigned i = 0; i < STRIDE; i++) begin
                    valid_mask[i] = ((gi * STRIDE + i) < NR_KEY);
                end
            end
        end
    end

    lut_group_match #(
        .STRIDE   (STRIDE),
        .KEY_LEN  (KEY_LEN),
        .DATA_LEN (DATA_LEN),
        .IDX_W    (IDX_W)
    ) u_match (
        .pairs       (window),
        .base_index  (base_index),
        .valid_mask  (valid_mask),
        .search_data (data_q),
        .hit         (m_hit),
        .key         (m_key),
        .index       (m_idx)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_valid) state_d = StScan;
            StScan:  if (m_hit || last_grp) state_d = StResp;
            StResp:  if (resp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
        end
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
    end

    // Request latch, group pointer and result registers; untouched while in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_q  <= '0;
            data_q <= '0;
            hit_q  <= 1'b0;
            key_q  <= '0;
            idx_q  <= '0;
        end else if (flush) begin
            grp_q <= '0;
            hit_q <= 1'b0;
            key_q <= '0;
            idx_q <= '0;
        end else if (accept) begin
            data_q <= req_data;
            grp_q  <= '0;
            hit_q  <= 1'b0;
            key_q  <= '0;
            idx_q  <= '0;
        end else if (state_q == StScan) begin
            if (m_hit) begin
                hit_q <= 1'b1;
                key_q <= m_key;
                idx_q <= m_idx;
            end else if (last_grp) begin
                hit_q <= 1'b0;
                key_q <= '0;
                idx_q <= '0;
            end else begin
                grp_q <= grp_q + GRP_W'(1);
            end
        end
    end

    assign resp_hit   = hit_q;
    assign resp_key   = key_q;
    assign resp_index = idx_q;

endmodule

// File: doc/lut_reverse_search.md
Name: lut_reverse_search

Overview:
- Sequential reverse lookup over the key/data LUT format used by the mux templates: given a data value, returns the key of the first LUT pair whose data field matches.
- Scans STRIDE pairs per cycle, exits early on the first hit, and returns the result on a valid/ready response channel.
- Used by NPC control and decode paths that need data-to-key mapping, such as reverse CSR or opcode lookup, where a full-width parallel compare is too costly.

Parameters:
- NR_KEY, 2, number of key/data pairs in lut.
- KEY_LEN, 1, key field width.
- DATA_LEN, 1, data field width.
- STRIDE, 1, pairs compared per cycle; legal range 1..NR_KEY.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; returns to IDLE and drops any pending result.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_data  in  DATA_LEN  value to search for.
- lut  in  NR_KEY*(KEY_LEN+DATA_LEN)  pair n = lut[PAIR_LEN*(n+1)-1 : PAIR_LEN*n]; key in the upper KEY_LEN bits, data in the lower DATA_LEN bits.
- resp_valid  out  1  result present.
- resp_ready  in  1  consumer accepts the result.
- resp_hit  out  1  a match was found.
- resp_key  out  KEY_LEN  key of the matching pair; 0 on miss.
- resp_index  out  IDX_W  index of the matching pair; 0 on miss. IDX_W = max(1, clog2(NR_KEY)).

Behaviour:
- States: IDLE, SCAN, RESP.
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - resp_valid, resp_hit, resp_key, resp_index = 0.
  - Internal group pointer and latched request = 0.
- req_ready = 1 only in IDLE. A request is accepted when req_valid && req_ready.
- IDLE, on accept: latch req_data, clear the group pointer g, go to SCAN.
- SCAN, each cycle: compare pairs g*STRIDE .. min(g*STRIDE+STRIDE, NR_KEY)-1 against the latched data.
  - Any match: take the lowest matching index, register hit = 1 with its key and index, go to RESP.
  - No match, not the last group: g += 1.
  - No match, last group: register hit = 0, key = 0, index = 0, go to RESP.
  - A partial last group compares only indices below NR_KEY.
- Priority among duplicate data values: the lowest index wins. No OR-merge.
- RESP: resp_valid = 1, with all resp_* held stable until resp_ready. On resp_valid && resp_ready, return to IDLE.
  - No overlap: the next request can be accepted at the earliest one cycle after the response handshake.
- Latency, with the request accepted at edge T and G = ceil(NR_KEY/STRIDE):
  - Hit in group g: resp_valid visible after edge T+1+g, i.e. in cycle T+2+g.
  - Miss: resp_valid visible in cycle T+1+G.
- flush = 1 in any state: next state IDLE, resp_valid = 0, result discarded. flush takes priority over an accept or response handshake in the same cycle.
- Reset asserted mid-SCAN or mid-RESP: outputs clear immediately; no response is produced.
- The request is ignored when req_valid is high outside IDLE.

Optional Feature:
- YSYX_22050039_LUT_SNAPSHOT_EN, defined:
  - On accept, the full lut is captured into an NR_KEY*PAIR_LEN register.
  - SCAN compares against this snapshot; lut changes after accept have no effect on the result.
- Undefined:
  - No snapshot register. SCAN reads lut live, so each group is compared with the lut value present in the cycle that group is scanned.
  - The caller holds lut stable from accept until the response handshake.

Decomposition:
- Shared package ysyx_22050039_lut_pkg:
  - State encoding (IDLE/SCAN/RESP).
  - PAIR_LEN and IDX_W derivation functions (clog2 with minimum 1).
- One combinational sub-module, lut_group_match: takes STRIDE pairs, a base index, a valid mask and the search data. It outputs hit, lowest matching key and index.
- The top level holds the FSM, the group pointer, the request/response registers and the optional snapshot.

Test Plan:
- Common setup: NR_KEY=4, KEY_LEN=3, DATA_LEN=8, STRIDE=1. lut pairs are {1:8'h10, 2:8'h20, 5:8'h20, 7:8'hFF}, written as key:data for idx0..3.
- Hit in first group: req_data 8'h10 accepted at T -> resp_valid in cycle T+2, hit=1, key=3'd1, index=0.
- Duplicate data: req_data 8'h20 -> key=3'd2, index=1, response in cycle T+3; index 2 never reported.
- Last pair and miss: req 8'hFF -> key=3'd7, index=3 in cycle T+5. req 8'h33 -> hit=0, key=0, index=0 in cycle T+5.
- STRIDE=2, req 8'hFF -> key 7, index 3 in cycle T+3. NR_KEY=3 with STRIDE=2 and a request for the data at pair idx2 -> correct hit from the partial group.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_* stable, req_ready=0, and a concurrent req_valid is ignored. Release -> IDLE, then the next request is accepted.
- Abort and snapshot:
  - flush or rst_n low mid-SCAN -> resp_valid stays 0 and req_ready=1 the next cycle.
  - With the macro defined, rewrite pair 3 data to 8'h00 one cycle after accepting a request for 8'hFF -> still hit, key 7.
  - Without the macro, the same stimulus -> miss.
